// File: rtl/firengine_pkg.sv
// firengine_pkg: sample width and sample type shared by the FIR, sample FIFO and I2S blocks.
package firengine_pkg;
  localparam int DataWidth = 12;
  typedef logic signed [DataWidth-1:0] sample_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones; clr wins over inc.
module sat_counter #(
  parameter int Width = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [Width-1:0] count
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) count <= '0;
    else if (clr) count <= '0;
    else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/dac_sample_fifo.sv
// dac_sample_fifo: elastic sample buffer between FIR output and the I2S DAC path,
// holding the last popped sample on outData while empty.
module dac_sample_fifo
  import firengine_pkg::*;
#(
  parameter int DataWidth  = firengine_pkg::DataWidth,
  parameter int Depth      = 4,
  parameter int CountWidth = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic signed [DataWidth-1:0]  inData,
  input  logic                         inValid,
  output logic signed [DataWidth-1:0]  outData,
  output logic                         outValid,
  input  logic                         outReady,
  input  logic                         flush,
  input  logic                         clearCounts,
  output logic [$clog2(Depth):0]       level,
  output logic                         full,
  output logic [CountWidth-1:0]        overflowCount,
  output logic [CountWidth-1:0]        underflowCount
);
  localparam int PtrWidth = $clog2(Depth);
  localparam int LevelWidth = PtrWidth + 1;
  localparam logic [LevelWidth-1:0] DepthLevel = LevelWidth'(Depth);
  logic signed [DataWidth-1:0] mem [Depth];
  logic signed [DataWidth-1:0] lastPopped;
  logic [PtrWidth-1:0] rdPtr, wrPtr;
  logic [LevelWidth-1:0] levelNext;
  logic pop, push, overflowEvt, underflowEvt;
  // flush suppresses every event, including the counter increments
  always_comb begin
    pop = outValid && outReady && !flush;
    push = inValid && (!full || pop) && !flush;
    overflowEvt = inValid && full && !pop && !flush;
    underflowEvt = outReady && !outValid && !flush;
    levelNext = flush ? '0 : level + LevelWidth'(push) - LevelWidth'(pop);
  end
  assign outData = outValid ? mem[rdPtr] : lastPopped;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      level <= '0;
      full <= 1'b0;
      outValid <= 1'b0;
      lastPopped <= '0;
    end else begin
      rdPtr <= flush ? '0 : rdPtr + PtrWidth'(pop);
      wrPtr <= flush ? '0 : wrPtr + PtrWidth'(push);
      level <= levelNext;
      full <= levelNext == DepthLevel;
      outValid <= levelNext != '0;
      if (pop) lastPopped <= mem[rdPtr];
    end
  always_ff @(posedge clk)
    if (push) mem[wrPtr] <= inData;
  sat_counter #(.Width(CountWidth)) overflowCounter (
    .clk(clk), .reset(reset), .inc(overflowEvt), .clr(clearCounts), .count(overflowCount)
  );
  sat_counter #(.Width(CountWidth)) underflowCounter (
    .clk(clk), .reset(reset), .inc(underflowEvt), .clr(clearCounts), .count(underflowCount)
  );
endmodule

// File: doc/dac_sample_fifo.md
DAC_SAMPLE_FIFO -- requirements
Module: dac_sample_fifo

Purpose: elastic sample buffer between the FIR output (y/done) and the I2S DAC path; absorbs jitter between FIR completion and I2S frame timing.

Interface
REQ-001 SHALL have parameter DataWidth, default 12, sample width in bits.
REQ-002 SHALL have parameter Depth, default 4, entry count; power of two, at least 2.
REQ-003 SHALL have parameter CountWidth, default 4, width of each event counter.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port inData  input  DataWidth  signed sample from the FIR.
REQ-007 SHALL have port inValid  input  1  one-cycle pulse; inData is valid this cycle.
REQ-008 SHALL have port outData  output  DataWidth  head sample, or held sample when empty.
REQ-009 SHALL have port outValid  output  1  FIFO non-empty.
REQ-010 SHALL have port outReady  input  1  consumer takes a sample this cycle.
REQ-011 SHALL have port flush  input  1  synchronous clear of stored samples.
REQ-012 SHALL have port clearCounts  input  1  synchronous clear of both event counters.
REQ-013 SHALL have port level  output  $clog2(Depth)+1  number of stored samples.
REQ-014 SHALL have port full  output  1  level equals Depth.
REQ-015 SHALL have port overflowCount  output  CountWidth  saturating count of dropped input samples.
REQ-016 SHALL have port underflowCount  output  CountWidth  saturating count of reads attempted while empty.

Function
REQ-017 SHALL accept a push when inValid=1 and (full=0 or a pop occurs in the same cycle).
REQ-018 SHALL perform a pop when outValid=1 and outReady=1.
REQ-019 SHALL make a pushed sample visible on outData/outValid exactly 1 cycle after the push when empty; there is no same-cycle bypass.
REQ-020 SHALL drive outData from the head entry when non-empty, and from the lastPopped register when empty.
REQ-021 SHALL load lastPopped with the popped head value on every pop.
REQ-022 SHALL drop inData, leave the FIFO unchanged, and increment overflowCount when inValid=1, full=1 and no pop occurs.
REQ-023 SHALL increment underflowCount when outReady=1 and outValid=0; pointers and level SHALL remain unchanged.
REQ-024 SHALL hold both counters at all-ones once saturated, with no wrap.
REQ-025 SHALL wrap read and write pointers modulo Depth; level SHALL update by +1 (push only), -1 (pop only) or 0 (both, or neither).
REQ-026 SHALL give flush priority over push and pop: pointers and level go to 0, the push is discarded, and lastPopped and the counters are unchanged.
REQ-027 SHALL, when clearCounts and a counting event coincide, end the cycle with that counter at 0.
REQ-028 SHALL register all outputs except outData, which is a combinational mux of registered state.

Reset
REQ-029 SHALL, while reset=0, asynchronously force: pointers 0, level 0, full 0, outValid 0, lastPopped 0 (so outData=0), both counters 0.
REQ-030 SHALL discard any sample stored when reset asserts mid-operation; the first push after release appears 1 cycle later.

Structure
REQ-031 SHALL take DataWidth and a sample_t typedef (logic signed [DataWidth-1:0]) from shared package firengine_pkg, which the FIR and I2S blocks also use.
REQ-032 SHALL implement each event counter as an instance of sub-module sat_counter (parameter Width; inputs inc, clr; output count).
REQ-033 SHALL store samples in a register array with no inferred RAM.

Verification
REQ-034 Push 0x123, 0x456 with outReady=0 -> cycle after first push: outValid=1, outData=0x123; level=2.
REQ-035 Push 5 samples into Depth=4 with outReady=0 -> full=1, level=4, overflowCount=1; pop order returns the first four samples.
REQ-036 When full, apply inValid and outReady together -> push accepted, level stays 4, overflowCount unchanged.
REQ-037 Drain to empty after last value 0x7FF, then hold outReady=1 for 3 cycles -> outData=0x7FF, outValid=0, underflowCount=3.
REQ-038 Apply 20 overflow events with CountWidth=4 -> overflowCount=15 held; then pulse clearCounts -> 0.
REQ-039 With level=3, assert reset=0 asynchronously mid-cycle -> outValid=0, level=0 and outData=0 immediately; with flush instead -> level=0 and outData equals the last popped value.
